bus_arbiter: RTL and testbench

Shares the single external memory bus between the 8227 CPU core and a DMA requester (program loader / debug port). The arbiter sits between the core's address/data pins and memory and drives the core's `ready` input. It stalls the CPU only on read cycles, because the core ignores `ready` during writes. It also bounds DMA bursts so the CPU is never starved.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_mux.sv | 43 ++++
 rtl/bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_bus_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the 8227 memory-bus arbiter and the top-level integration.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  // Bus ownership phases of the arbiter.
  typedef enum logic [1:0] {
    CPU_OWN,
    DRAIN,
    DMA_OWN,
    COOLDOWN
  } arb_state_t;

endpackage

// File: rtl/bus_mux.sv
// CPU/DMA select for memory address, write data and write strobe.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owner bit comes from the arbiter's registered state.
//
// Ports:
//   dma_sel            - 1 = DMA owns the bus (registered owner bit)
//   dma_last           - final cycle of the current DMA transfer
//   cpu_*              - core address, write data, direction and strobe
//   dma_*              - DMA address, write data and direction
//   mem_*              - muxed memory address, write data and write enable
module bus_mux
  import bus_pkg::*;
(
  input  logic                  dma_sel,
  input  logic                  dma_last,
  input  logic [BUS_ADDR_W-1:0] cpu_addr,
  input  logic [BUS_DATA_W-1:0] cpu_wdata,
  input  logic                  cpu_rnw,
  input  logic                  cpu_strobe,
  input  logic [BUS_ADDR_W-1:0] dma_addr,
  input  logic [BUS_DATA_W-1:0] dma_wdata,
  input  logic                  dma_write,
  output logic [BUS_ADDR_W-1:0] mem_addr,
  output logic [BUS_DATA_W-1:0] mem_wdata,
  output logic                  mem_we
);

  always_comb begin
    if (dma_sel) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      // Memory only sees the DMA write once the wait states have elapsed.
      mem_we    = dma_write & dma_last;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      // Core writes pass straight through, also while ready is withdrawn,
      // because the core ignores ready on write cycles.
      mem_we    = ~cpu_rnw & cpu_strobe;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the external memory bus between the 8227 core and a DMA requester.
// Latency: request -> cpuReady low 1 cycle; grant 1 cycle after the first read strobe
//   while draining; each DMA transfer lasts WAIT_STATES+1 cycles, acked in its last cycle.
// Backpressure: stalls the core through cpuReady (reads only); DMA bursts are capped at
//   MAX_BURST transfers and followed by at least one core bus cycle.
//
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   cpuAddress/cpuDataOut/cpuReadNotWrite/cpuStrobe - core bus-cycle inputs
//   cpuReady                          - core ready input
//   dmaReq/dmaAddress/dmaWriteData/dmaWrite - DMA request level and transfer
//   dmaGrant/dmaAck                   - DMA owns bus / transfer complete pulse
//   memAddress/memWriteData/memWriteEnable - muxed memory bus
//   memReadData                       - memory read data (forwarded outside this block)
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_ADDR_W-1:0] cpuAddress,
  input  logic [BUS_DATA_W-1:0] cpuDataOut,
  input  logic                  cpuReadNotWrite,
  input  logic                  cpuStrobe,
  output logic                  cpuReady,
  input  logic                  dmaReq,
  input  logic [BUS_ADDR_W-1:0] dmaAddress,
  input  logic [BUS_DATA_W-1:0] dmaWriteData,
  input  logic                  dmaWrite,
  output logic                  dmaGrant,
  output logic                  dmaAck,
  output logic [BUS_ADDR_W-1:0] memAddress,
  output logic [BUS_DATA_W-1:0] memWriteData,
  output logic                  memWriteEnable,
  input  logic [BUS_DATA_W-1:0] memReadData
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_t state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] burst_inc;
  logic       cpu_ready_q, cpu_ready_d;
  logic       owner_q, owner_d;
  logic       dma_ack_q, dma_ack_d;

  // Read data is routed outside this block; it is listed here only to keep the
  // pin list complete for integration.
  logic       unused_rdata;
  assign unused_rdata = ^memReadData;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    // Saturating increment: the burst count never wraps past the limit.
    burst_inc   = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 8'd1 : burst_cnt_q;

    unique case (state_q)
      CPU_OWN: begin
        if (dmaReq) state_d = DRAIN;
      end
      DRAIN: begin
        // A dropped request wins over a simultaneous read strobe.
        if (!dmaReq) begin
          state_d = CPU_OWN;
        end else if (cpuStrobe && cpuReadNotWrite) begin
          // A read strobe with ready low means the core is now halted.
          state_d     = DMA_OWN;
          burst_cnt_d = 8'd0;
          wait_cnt_d  = WAIT_LOAD;
        end
      end
      DMA_OWN: begin
        if (wait_cnt_q != 3'd0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          // Transfer boundary: the request level is only honoured here,
          // so a release mid-transfer still lets the transfer finish.
          burst_cnt_d = burst_inc;
          wait_cnt_d  = WAIT_LOAD;
          if (!dmaReq || (burst_inc >= BURST_MAX)) state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cpuStrobe) state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase

    // Outputs are registered from the next-state view so that they line up
    // with the state they describe.
    cpu_ready_d = (state_d == CPU_OWN) || (state_d == COOLDOWN);
    owner_d     = (state_d == DMA_OWN);
    dma_ack_d   = (state_d == DMA_OWN) && (wait_cnt_d == 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CPU_OWN;
      wait_cnt_q  <= 3'd0;
      burst_cnt_q <= 8'd0;
      cpu_ready_q <= 1'b1;
      owner_q     <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cpu_ready_q <= cpu_ready_d;
      owner_q     <= owner_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign cpuReady = cpu_ready_q;
  assign dmaGrant = owner_q;
  assign dmaAck   = dma_ack_q;

  // The ack marks the last cycle of a transfer, which is also when the DMA
  // write strobe is allowed through.
  bus_mux u_mux (
    .dma_sel    (owner_q),
    .dma_last   (dma_ack_q),
    .cpu_addr   (cpuAddress),
    .cpu_wdata  (cpuDataOut),
    .cpu_rnw    (cpuReadNotWrite),
    .cpu_strobe (cpuStrobe),
    .dma_addr   (dmaAddress),
    .dma_wdata  (dmaWriteData),
    .dma_write  (dmaWrite),
    .mem_addr   (memAddress),
    .mem_wdata  (memWriteData),
    .mem_we     (memWriteEnable)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios then randomized traffic.
// Expected per-cycle bus view comes from a transaction-level model of the sharing rules.
// Stimulus pushes expectations; an independent negedge monitor pops and compares.
module tb_bus_arbiter;

  localparam int WS = 1;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataOut;
  logic        cpuReadNotWrite, cpuStrobe, cpuReady;
  logic        dmaReq;
  logic [15:0] dmaAddress;
  logic [7:0]  dmaWriteData;
  logic        dmaWrite, dmaGrant, dmaAck;
  logic [15:0] memAddress;
  logic [7:0]  memWriteData;
  logic        memWriteEnable;
  logic [7:0]  memReadData;

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_STATES(WS), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut),
    .cpuReadNotWrite(cpuReadNotWrite), .cpuStrobe(cpuStrobe), .cpuReady(cpuReady),
    .dmaReq(dmaReq), .dmaAddress(dmaAddress), .dmaWriteData(dmaWriteData),
    .dmaWrite(dmaWrite), .dmaGrant(dmaGrant), .dmaAck(dmaAck),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable), .memReadData(memReadData)
  );

  // Simple memory attached to the muxed bus.
  assign memReadData = mem[memAddress];
  always @(posedge clk) if (memWriteEnable === 1'b1) mem[memAddress] <= memWriteData;

  typedef struct packed {
    logic        rdy;
    logic        gnt;
    logic        ack;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ack_cnt = 0;
  bit   gnt_seen = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endfunction

  // Monitor: compares whatever the DUT presents against the next expectation.
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{cpuReady, dmaGrant, dmaAck, memWriteEnable, memAddress, memWriteData};
      check("bus_cycle {rdy,gnt,ack,we,addr,wd}", 32'(a), 32'(e));
    end
    if (dmaAck === 1'b1) ack_cnt++;
    if (dmaGrant === 1'b1) gnt_seen = 1'b1;
  end

  // Reference model: who owns the bus, and how far through the burst we are.
  bit m_dma;      // DMA holds the bus, core halted
  bit m_stall;    // ready withdrawn, waiting for the core to halt on a read
  bit m_owe;      // core is owed one bus cycle before the next request is heard
  int m_left;     // cycles left in the current transfer, including this one
  int m_done;     // transfers completed under this grant

  task automatic m_reset();
    m_dma = 0; m_stall = 0; m_owe = 0; m_left = 0; m_done = 0;
  endtask

  task automatic m_advance();
    if (m_dma) begin
      if (m_left == 1) begin
        m_done++;
        if (!dmaReq || m_done == MB) begin
          m_dma = 0;
          m_owe = 1;
        end else begin
          m_left = WS + 1;
        end
      end else begin
        m_left--;
      end
    end else if (m_owe) begin
      if (cpuStrobe) m_owe = 0;
    end else if (m_stall) begin
      if (!dmaReq) m_stall = 0;
      else if (cpuStrobe && cpuReadNotWrite) begin
        m_stall = 0; m_dma = 1; m_left = WS + 1; m_done = 0;
      end
    end else if (dmaReq) begin
      m_stall = 1;
    end
  endtask

  // One bus cycle: inputs are already set; predict this cycle, then clock it.
  task automatic step();
    obs_t e;
    if (rst) m_reset();
    e.rdy  = !m_stall && !m_dma;
    e.gnt  = m_dma;
    e.ack  = m_dma && (m_left == 1);
    e.we   = m_dma ? (e.ack && dmaWrite) : (cpuStrobe && !cpuReadNotWrite);
    e.addr = m_dma ? dmaAddress : cpuAddress;
    e.wd   = m_dma ? dmaWriteData : cpuDataOut;
    exp_q.push_back(e);
    if (!rst) m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic stb, input logic rnw, input logic [15:0] a, input logic [7:0] d);
    cpuStrobe = stb; cpuReadNotWrite = rnw; cpuAddress = a; cpuDataOut = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu(1'b1, 1'b1, 16'h1000 + 16'(i), 8'h00);
      step();
    end
  endtask

  int a0;

  initial begin
    rst = 1'b1; dmaReq = 0; dmaAddress = 0; dmaWriteData = 0; dmaWrite = 0;
    cpu(1'b0, 1'b1, 16'h0000, 8'h00);
    m_reset();
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    idle(3);

    // Basic grant and burst limit: core reads every strobe, request held.
    a0 = ack_cnt;
    dmaReq = 1; dmaWrite = 0;
    for (int i = 0; i < 10; i++) begin
      dmaAddress = 16'h3000 + 16'(i);
      cpu(1'b1, 1'b1, 16'h2000 + 16'(i), 8'h00);
      step();
    end
    check("burst_limit_acks", 32'(ack_cnt - a0), 32'(MB));
    for (int i = 0; i < 4; i++) begin
      cpu(1'b1, 1'b1, 16'h2100 + 16'(i), 8'h00);
      step();
    end
    dmaReq = 0;
    idle(4);

    // Write drain: three core writes with the request pending, then a read.
    gnt_seen = 0;
    dmaReq = 1; dmaAddress = 16'h3100;
    cpu(1'b1, 1'b0, 16'h0100, 8'h11); step();
    cpu(1'b1, 1'b0, 16'h0101, 8'h22); step();
    cpu(1'b1, 1'b0, 16'h0102, 8'h33); step();
    cpu(1'b1, 1'b1, 16'h0103, 8'h00); step();
    check("drain_no_early_grant", 32'(gnt_seen), 32'd0);
    dmaReq = 0;
    cpu(1'b0, 1'b1, 16'h0104, 8'h00); step(); step();
    idle(3);
    check("drain_wr0", 32'(mem[16'h0100]), 32'h11);
    check("drain_wr1", 32'(mem[16'h0101]), 32'h22);
    check("drain_wr2", 32'(mem[16'h0102]), 32'h33);

    // Mid-transfer release during a DMA write.
    dmaReq = 1; dmaWrite = 1; dmaAddress = 16'h0200; dmaWriteData = 8'hA5;
    cpu(1'b0, 1'b1, 16'h0300, 8'h00); step();
    cpu(1'b1, 1'b1, 16'h0300, 8'h00); step();
    a0 = ack_cnt;
    cpu(1'b0, 1'b1, 16'h0300, 8'h00); step();
    dmaReq = 0; step();
    dmaWrite = 0;
    idle(4);
    check("release_one_ack", 32'(ack_cnt - a0), 32'd1);
    check("release_mem_0200", 32'(mem[16'h0200]), 32'hA5);

    // Abandoned request: one-cycle pulse followed by a core read.
    gnt_seen = 0;
    dmaReq = 1; cpu(1'b0, 1'b1, 16'h0400, 8'h00); step();
    dmaReq = 0; idle(5);
    check("abandon_no_grant", 32'(gnt_seen), 32'd0);

    // Reset in the middle of a transfer: the in-flight transfer is never acked.
    dmaReq = 1; dmaWrite = 1; dmaAddress = 16'h0500; dmaWriteData = 8'h5A;
    cpu(1'b1, 1'b1, 16'h0600, 8'h00); step(); step(); step();
    a0 = ack_cnt;
    rst = 1'b1; dmaReq = 0; step();
    rst = 1'b0; idle(3);
    check("reset_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("reset_no_write", 32'(mem[16'h0500] === 8'h5A), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) dmaReq = ~dmaReq;
      dmaAddress   = 16'($urandom);
      dmaWriteData = 8'($urandom);
      dmaWrite     = 1'($urandom_range(0, 1));
      cpu(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          16'($urandom), 8'($urandom));
      step();
    end
    dmaReq = 0;
    idle(4);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
